pipe_array: RTL
===============

PIPE_ARRAY -- requirements
Module: pipe_array

Interface
REQ-001 SHALL have parameter N_PIPES, default 3, number of independent pipe pairs (1..4).
REQ-002 SHALL have parameter PIPE_W, default 41, sprite width in pixels.
REQ-003 SHALL have parameter PIPE_H, default 253, sprite height in rows.
REQ-004 SHALL have parameter GAP_H, default 96, vertical opening between top and bottom pipe.
REQ-005 SHALL have parameter SPACING, default 213, horizontal distance between consecutive pipes.
REQ-006 SHALL have parameter BIRD_X, default 160, bird column used for scoring.
REQ-007 SHALL have parameter SCREEN_W, default 640, and parameter SCREEN_H, default 480.
REQ-008 SHALL have port system_clk, input, 1 bit: the only clock.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-010 SHALL have port game_tick, input, 1 bit: one-cycle movement strobe synchronous to system_clk.
REQ-011 SHALL have port freeze, input, 1 bit: halts motion and respawn.
REQ-012 SHALL have port veciloty, input, 2 bits: pixels moved per tick.
REQ-013 SHALL have ports pixel_x and pixel_y, input, 10 bits each: current scan position.
REQ-014 SHALL have port rom_addr, output, 14 bits: sprite ROM address.
REQ-015 SHALL have port pipe_on, output, 1 bit: pixel lies inside any pipe.
REQ-016 SHALL have port score_tick, output, 1 bit: one-cycle pass pulse.
REQ-017 SHALL have port pipe_l_flat, output, N_PIPES*11 bits: signed left edges, packed.
REQ-018 SHALL have port gap_t_flat, output, N_PIPES*10 bits: gap top rows, packed.

Function
REQ-019 SHALL store each left edge x_l[i] as 11-bit two's complement so pipes can go partly off the left edge; x_r[i] = x_l[i] + PIPE_W - 1.
REQ-020 SHALL, on game_tick with freeze low, subtract veciloty from every x_l[i]; veciloty = 0 holds position.
REQ-021 SHALL, in the same tick, respawn pipe i when its updated x_r[i] < 0: x_l[i] += N_PIPES*SPACING, and gap_t[i] takes the next gap value.
REQ-022 SHALL draw one gap value per respawning pipe when several respawn in the same tick, lowest index first.
REQ-023 SHALL pulse score_tick for one cycle when any x_r[i] goes from >= BIRD_X to < BIRD_X on a tick; simultaneous crossings give one pulse.
REQ-024 SHALL mark a pixel as a hit for pipe i when x_l[i] <= pixel_x <= x_r[i] and either (top) pixel_y < gap_t[i] or (bottom) pixel_y >= gap_t[i] + GAP_H.
REQ-025 SHALL compute col = pixel_x - x_l[i].
REQ-026 SHALL compute row = gap_t[i] - 1 - pixel_y for a top pipe (vertically flipped) or pixel_y - gap_t[i] - GAP_H for a bottom pipe.
REQ-027 SHALL clamp row to PIPE_H - 1 when it exceeds that value.
REQ-028 SHALL compute rom_addr = col + PIPE_W*row, truncated to 14 bits.
REQ-029 SHALL give priority to the lowest index when pipes overlap.
REQ-030 SHALL register rom_addr and pipe_on, for a latency of exactly 1 cycle from pixel_x/pixel_y; with the 1-cycle ROM this aligns ROM data to 2 cycles.
REQ-031 SHALL hold rom_addr at its previous value when pipe_on is 0.

Reset
REQ-032 SHALL, while reset is low, force x_l[i] = SCREEN_W + i*SPACING, gap_t[i] = first gap values in index order, rom_addr = 0, pipe_on = 0, score_tick = 0, and the gap generator to its seed.
REQ-033 SHALL abort any in-progress tick update when reset is asserted mid-operation; no partial respawn is retained.

Configuration
REQ-034 SHALL, with PIPE_LFSR_EN defined, use an 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5; never all-zero) advanced once per draw; gap = 64 + lfsr[7:1].
REQ-035 SHALL, without PIPE_LFSR_EN, draw gaps cyclically from the fixed table 80, 160, 120, 200 using a 2-bit index reset to 0.

Structure
REQ-036 SHALL keep the gap table, LFSR seed, GAP_MIN = 64 and the screen constants in a shared package, pipe_pkg.
REQ-037 SHALL implement gap generation, in both modes, as the single sub-module pipe_gap_gen, with ports system_clk, reset, draw and gap[9:0].

Verification
REQ-038 Bench SHALL check: reset release with N_PIPES=3 -> x_l = 640, 853, 1066, and (macro off) gap_t = 80, 160, 120.
REQ-039 Bench SHALL check: veciloty=2 with 100 ticks -> x_l[0] = 440, and one score_tick per pipe crossing BIRD_X=160.
REQ-040 Bench SHALL check: x_l[0] = -40 with veciloty=1 and one tick -> x_r = -1, respawn to x_l = 598, gap_t[0] = 200 (macro off, 4th draw).
REQ-041 Bench SHALL check: pixel (x_l+5, gap_t-1) -> one cycle later pipe_on = 1 and rom_addr = 5; pixel (x_l+5, gap_t+GAP_H+2) -> rom_addr = 5 + 41*2 = 87.
REQ-042 Bench SHALL check: freeze high, or veciloty=0, over 50 ticks -> all x_l unchanged and no score_tick.
REQ-043 Bench SHALL check: reset asserted while a tick respawns pipe 0 -> all outputs immediately at their reset values, with the LFSR seeded at 8'hA5 (macro on).

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state type and gap helpers for pipe_array
// Macro PIPE_LFSR_EN selects the LFSR gap source instead of the fixed gap table.
package pipe_pkg;

  localparam int         SCREEN_W_DEF = 640;
  localparam int         SCREEN_H_DEF = 480;
  localparam int         GAP_MIN      = 64;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  localparam logic [9:0] GAP_TABLE [4] = '{10'd80, 10'd160, 10'd120, 10'd200};

  // Positions carry one bit beyond the 11-bit output so spawn points past 1023 stay positive.
  localparam int POS_W = 12;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT
  } pipe_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [9:0] lfsr_gap(input logic [7:0] l);
    return 10'(GAP_MIN) + {3'b000, l[7:1]};
  endfunction

  function automatic logic [9:0] first_gap(input int k);
`ifdef PIPE_LFSR_EN
    logic [7:0] l;
    l = LFSR_SEED;
    for (int j = 0; j < k; j++) l = lfsr_next(l);
    return lfsr_gap(l);
`else
    logic [1:0] ki;
    ki = 2'(k);
    return GAP_TABLE[ki];
`endif
  endfunction

endpackage

// File: rtl/pipe_array_if.sv
// rtl/pipe_array_if.sv - pixel scan position in, sprite address and hit flag out
interface pipe_array_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [13:0] rom_addr;
  logic        pipe_on;

  modport master (output pixel_x, output pixel_y, input rom_addr, input pipe_on);
  modport slave  (input pixel_x, input pixel_y, output rom_addr, output pipe_on);
endinterface

// File: rtl/pipe_gap_gen.sv
// rtl/pipe_gap_gen.sv - gap row source, one new value per draw strobe
// Macro PIPE_LFSR_EN: 8-bit Fibonacci LFSR; otherwise cycles the fixed gap table.
module pipe_gap_gen
  import pipe_pkg::*;
(
  input  logic       system_clk,
  input  logic       reset,
  input  logic       draw,
  output logic [9:0] gap
);

`ifdef PIPE_LFSR_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (draw) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign gap = lfsr_gap(r_lfsr);
`else
  logic [1:0] r_idx;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_idx <= 2'd0;
    end else if (draw) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  assign gap = GAP_TABLE[r_idx];
`endif

endmodule

// File: rtl/pipe_array.sv
// rtl/pipe_array.sv - scrolling pipe pairs with respawn, scoring and sprite addressing
// Macro PIPE_LFSR_EN selects the LFSR gap generator (see pipe_gap_gen).
module pipe_array
  import pipe_pkg::*;
#(
  parameter int N_PIPES  = 3,
  parameter int PIPE_W   = 41,
  parameter int PIPE_H   = 253,
  parameter int GAP_H    = 96,
  parameter int SPACING  = 213,
  parameter int BIRD_X   = 160,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                   system_clk,
  input  logic                   reset,
  input  logic                   game_tick,
  input  logic                   freeze,
  input  logic [1:0]             veciloty,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  output logic [13:0]            rom_addr,
  output logic                   pipe_on,
  output logic                   score_tick,
  output logic [N_PIPES*11-1:0]  pipe_l_flat,
  output logic [N_PIPES*10-1:0]  gap_t_flat
);

  typedef logic signed [POS_W-1:0] pos_t;

  localparam pos_t        W_M1     = pos_t'(PIPE_W - 1);
  localparam pos_t        BIRD     = pos_t'(BIRD_X);
  localparam pos_t        SPAWN_D  = pos_t'(N_PIPES * SPACING);
  localparam logic [1:0]  IDX_LAST = 2'(N_PIPES - 1);
  localparam logic [10:0] GAP_H11  = 11'(GAP_H);
  localparam logic [10:0] ROW_MAX  = 11'(PIPE_H - 1);
  localparam logic [13:0] PW14     = 14'(PIPE_W);

  if (N_PIPES < 1 || N_PIPES > 4) begin : g_bad_n
    $error("pipe_array: N_PIPES must be in 1..4");
  end
  if (GAP_H >= SCREEN_H) begin : g_bad_gap
    $error("pipe_array: GAP_H must be smaller than SCREEN_H");
  end

  pipe_state_t        r_state;
  logic [1:0]         r_idx;
  logic [N_PIPES-1:0] r_need;
  logic               r_draw;
  logic               r_score;
  pos_t               r_x   [N_PIPES];
  logic [9:0]         r_gap [N_PIPES];
  logic               r_pipe_on;
  logic [13:0]        r_rom_addr;

  logic [9:0]         w_gap;
  logic               w_tick;
  pos_t               w_next   [N_PIPES];
  logic [N_PIPES-1:0] w_resp;
  logic [N_PIPES-1:0] w_cross;
  logic [N_PIPES-1:0] w_hit;
  logic [13:0]        w_addr_p [N_PIPES];
  logic               w_any;
  logic [13:0]        w_addr;

  pipe_gap_gen u_gap (
    .system_clk (system_clk),
    .reset      (reset),
    .draw       (r_draw),
    .gap        (w_gap)
  );

  for (genvar g = 0; g < N_PIPES; g++) begin : g_pipe
    pos_t        w_xr_old;
    pos_t        w_xr_new;
    pos_t        w_px;
    pos_t        w_dx;
    logic [10:0] w_py;
    logic [10:0] w_gt;
    logic [10:0] w_gb;
    logic [10:0] w_row_raw;
    logic [10:0] w_row;
    logic        w_in_x;
    logic        w_top;
    logic        w_bot;

    assign w_next[g]   = r_x[g] - pos_t'({1'b0, veciloty});
    assign w_xr_old    = r_x[g] + W_M1;
    assign w_xr_new    = w_next[g] + W_M1;
    assign w_resp[g]   = w_xr_new[POS_W-1];
    assign w_cross[g]  = (w_xr_old >= BIRD) && (w_xr_new < BIRD);

    assign w_px        = pos_t'({2'b00, pixel_x});
    assign w_dx        = w_px - r_x[g];
    assign w_in_x      = (w_px >= r_x[g]) && (w_dx <= W_M1);

    assign w_py        = {1'b0, pixel_y};
    assign w_gt        = {1'b0, r_gap[g]};
    assign w_gb        = w_gt + GAP_H11;
    assign w_top       = w_py < w_gt;
    assign w_bot       = w_py >= w_gb;
    // Top pipe sprite is drawn upside down, so its row counts upward from the gap.
    assign w_row_raw   = w_top ? (w_gt - 11'd1 - w_py) : (w_py - w_gb);
    assign w_row       = (w_row_raw > ROW_MAX) ? ROW_MAX : w_row_raw;

    assign w_hit[g]    = w_in_x && (w_top || w_bot);
    assign w_addr_p[g] = {2'b00, w_dx} + PW14 * {3'b000, w_row};

    assign pipe_l_flat[g*11 +: 11] = r_x[g][10:0];
    assign gap_t_flat[g*10 +: 10]  = r_gap[g];
  end

  always_comb begin
    w_any  = 1'b0;
    w_addr = '0;
    for (int i = N_PIPES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any  = 1'b1;
        w_addr = w_addr_p[i];
      end
    end
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_pipe_on  <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_pipe_on <= w_any;
      if (w_any) begin
        r_rom_addr <= w_addr;
      end
    end
  end

  assign w_tick = game_tick && !freeze && (r_state == S_IDLE);

  // Leaving reset replays the first N draws into the gaps, so the generator ends up
  // positioned for the first respawn.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_SCAN;
      r_idx   <= 2'd0;
      r_need  <= '1;
      r_draw  <= 1'b0;
      r_score <= 1'b0;
      for (int i = 0; i < N_PIPES; i++) begin
        r_x[i]   <= pos_t'(SCREEN_W + i * SPACING);
        r_gap[i] <= first_gap(i);
      end
    end else begin
      r_draw  <= 1'b0;
      r_score <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            for (int i = 0; i < N_PIPES; i++) begin
              r_x[i] <= w_resp[i] ? (w_next[i] + SPAWN_D) : w_next[i];
            end
            r_need  <= w_resp;
            r_score <= |w_cross;
            r_idx   <= 2'd0;
            if (|w_resp) begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (r_need[r_idx]) begin
            r_gap[r_idx]  <= w_gap;
            r_need[r_idx] <= 1'b0;
            r_draw        <= 1'b1;
            r_state       <= S_WAIT;
          end else if (r_idx == IDX_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_WAIT: begin
          if (r_idx == IDX_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_state <= S_SCAN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign score_tick = r_score;
  assign pipe_on    = r_pipe_on;
  assign rom_addr   = r_rom_addr;

endmodule
